mtr_pwm_decode: RTL

Recovers the signed left/right wheel speed commands from the four motor-drive PWM lines (lftPWM1/2, rghtPWM1/2) by measuring PWM1 high time over each 2048-cycle PWM period. It is the inverse of the motor-drive path (speed − 0x400 → 11-bit duty → PWM) and sits in the motor-model / bench-monitor side of the design, single clock domain with the driver. Outputs are register-stable between periods, with a one-cycle valid strobe per new measurement.

---
 rtl/mtr_pwm_decode.sv | 109 ++++++++++
 1 files changed

// File: rtl/mtr_pwm_decode.sv
// mtr_pwm_decode: recovers signed wheel speeds from PWM1 high time over each 2^PWM_W-cycle period.
// Define MTR_PWM_CHK_EN to add sticky shoot-through / deadtime-overrun fault detection.
module mtr_pwm_chan #(
    parameter int PWM_W = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p1,
    input  logic                    clr_err,
    output logic signed [PWM_W-1:0] spd,
    output logic                    vld,
    output logic                    err
);
    localparam logic [PWM_W:0]   PER = {1'b1, {PWM_W{1'b0}}};
    localparam logic [PWM_W:0]   SAT = {1'b1, {(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W:0]   ONE = {{PWM_W{1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] MSB = {1'b1, {(PWM_W-1){1'b0}}};
    logic             p1_q, seen, rise, err_set;
    logic [PWM_W:0]   per, hi;
    always_comb begin
        rise    = p1 & ~p1_q;
        err_set = rise ? (per != PER && seen) : (per == PER && p1);
    end
    // A full period ends either at a rise exactly PER cycles after the last one, or at a low timeout (duty 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q <= 1'b0;
            per  <= '0;
            hi   <= '0;
            spd  <= '0;
            vld  <= 1'b0;
            err  <= 1'b0;
            seen <= 1'b0;
        end else begin
            p1_q <= p1;
            vld  <= 1'b0;
            err  <= err_set | (err & ~clr_err);
            if (rise) begin
                per <= ONE;
                hi  <= ONE;
                if (per == PER) begin
                    spd  <= hi[PWM_W-1:0] ^ MSB;
                    vld  <= 1'b1;
                    seen <= 1'b1;
                end
            end else if (per == PER && !p1) begin
                spd  <= MSB;
                vld  <= 1'b1;
                seen <= 1'b1;
                per  <= ONE;
                hi   <= '0;
            end else begin
                per <= (per == SAT) ? per : per + ONE;
                hi  <= hi + {{PWM_W{1'b0}}, p1};
            end
        end
    end
endmodule

module mtr_pwm_decode #(
    parameter int PWM_W = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lftPWM1,
    input  logic                    lftPWM2,
    input  logic                    rghtPWM1,
    input  logic                    rghtPWM2,
    input  logic                    clr_err,
    output logic signed [PWM_W-1:0] lft_spd_meas,
    output logic signed [PWM_W-1:0] rght_spd_meas,
    output logic                    lft_vld,
    output logic                    rght_vld,
    output logic                    lft_err,
    output logic                    rght_err,
    output logic                    fault
);
    mtr_pwm_chan #(.PWM_W(PWM_W)) u_lft (
        .clk(clk), .rst_n(rst_n), .p1(lftPWM1), .clr_err(clr_err),
        .spd(lft_spd_meas), .vld(lft_vld), .err(lft_err)
    );
    mtr_pwm_chan #(.PWM_W(PWM_W)) u_rght (
        .clk(clk), .rst_n(rst_n), .p1(rghtPWM1), .clr_err(clr_err),
        .spd(rght_spd_meas), .vld(rght_vld), .err(rght_err)
    );
`ifdef MTR_PWM_CHK_EN
    logic [6:0] dl_l, dl_r;
    logic       fault_set;
    // dl_* counts prior consecutive both-low cycles; the 65th such cycle is an overrun.
    always_comb fault_set = (lftPWM1 & lftPWM2) | (rghtPWM1 & rghtPWM2) |
                            (~(lftPWM1 | lftPWM2) & (dl_l == 7'd64)) |
                            (~(rghtPWM1 | rghtPWM2) & (dl_r == 7'd64));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_l  <= '0;
            dl_r  <= '0;
            fault <= 1'b0;
        end else begin
            dl_l  <= (lftPWM1 | lftPWM2) ? 7'd0 : ((dl_l == 7'd64) ? dl_l : dl_l + 7'd1);
            dl_r  <= (rghtPWM1 | rghtPWM2) ? 7'd0 : ((dl_r == 7'd64) ? dl_r : dl_r + 7'd1);
            fault <= fault_set | (fault & ~clr_err);
        end
    end
`else
    logic unused_pwm2;
    assign unused_pwm2 = lftPWM2 ^ rghtPWM2;
    assign fault = 1'b0;
`endif
endmodule
